// File: rtl/configPackage.sv
// Shared video configuration for the test pattern generator: coordinate
// widths, the pattern-index enum and the colour-bar table.
package configPackage;

  localparam int VIDEO_X_BITWIDTH = 12;
  localparam int VIDEO_Y_BITWIDTH = 11;

  typedef enum logic [2:0] {
    PAT_BORDER      = 3'd0,
    PAT_COLOUR_BARS = 3'd1,
    PAT_CHECKER     = 3'd2,
    PAT_GREY_RAMP   = 3'd3,
    PAT_SOLID_RED   = 3'd4,
    PAT_SOLID_GREEN = 3'd5,
    PAT_SOLID_BLUE  = 3'd6,
    PAT_MOVING_BAR  = 3'd7
  } pattern_e;

  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
  localparam logic [23:0] RGB_BLACK = 24'h000000;

  // Left-to-right bar colours: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [23:0] COLOUR_BAR_TABLE [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Next pattern index, wrapping from count-1 back to 0.
  function automatic logic [2:0] next_pattern(input logic [2:0] idx, input int unsigned count);
    if (({29'd0, idx} + 32'd1) >= count) return 3'd0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus counter debounce for a raw push button.
// O_rise is a one-cycle pulse aligned with the debounced level going high.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic I_clk_pixel,
  input  logic I_reset,
  input  logic I_in,
  output logic O_level,
  output logic O_rise
);

  localparam logic [31:0] CNT_LAST = 32'(DEBOUNCE_CYCLES - 1);

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        sync_last_q, sync_last_d;
  logic        level_q, level_d;
  logic        rise_q, rise_d;
  logic [31:0] cnt_q, cnt_d;

  // Synchronise, restart the stability count on any change, accept the level once stable.
  always_comb begin
    // NOTE: every signal gets a default before the branches so no path leaves it unassigned (no latch).
    sync1_d     = I_in;
    sync2_d     = sync1_q;
    sync_last_d = sync2_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    if (sync2_q != sync_last_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
    rise_d = level_d & ~level_q;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge I_clk_pixel or posedge I_reset) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    if (I_reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync_last_q <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_last_q <= sync_last_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      rise_q      <= rise_d;
    end
  end

  assign O_level = level_q;
  assign O_rise  = rise_q;

endmodule

// File: rtl/test_pattern_gen.sv
// Video test pattern generator with a button (and optional timed) pattern
// advance that only takes effect at frame start. rgb is registered.
// Define TPG_MOVING_BAR_EN to build pattern 7 (moving bar) and its offset register.
module test_pattern_gen
  import configPackage::*;
#(
  parameter int NUM_PATTERNS      = 4,
  parameter int DEBOUNCE_CYCLES   = 270000,
  parameter int BORDER_W          = 8,
  parameter int AUTO_CYCLE_FRAMES = 0
) (
  input  logic                        I_clk_pixel,
  input  logic                        I_reset,
  input  logic                        I_button,
  input  logic [VIDEO_X_BITWIDTH-1:0] pixX,
  input  logic [VIDEO_Y_BITWIDTH-1:0] pixY,
  input  logic [VIDEO_X_BITWIDTH-1:0] screenWidth,
  input  logic [VIDEO_Y_BITWIDTH-1:0] screenHeight,
  output logic [23:0]                 rgb,
  output logic [2:0]                  pattern_idx,
  output logic                        frame_start
);

  localparam int XW = VIDEO_X_BITWIDTH;
  localparam int YW = VIDEO_Y_BITWIDTH;
`ifdef TPG_MOVING_BAR_EN
  localparam int unsigned EFF_PATTERNS = NUM_PATTERNS;
`else
  localparam int unsigned EFF_PATTERNS = (NUM_PATTERNS < 7) ? NUM_PATTERNS : 7;
`endif

  logic        btn_level, btn_rise;
  logic        frame_start_q, frame_start_d;
  logic        pending_q, pending_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]  pattern_idx_q, pattern_idx_d;
  logic [23:0] rgb_q, rgb_d;
  logic        auto_hit, advance;
  logic        in_area, on_border;
  logic [XW-1:0] bar_w;
  logic [XW+2:0] bar_thr;
  logic [2:0]    bar_sel;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .I_clk_pixel(I_clk_pixel),
    .I_reset    (I_reset),
    .I_in       (I_button),
    .O_level    (btn_level),
    .O_rise     (btn_rise)
  );

  // Frame detect and pattern advance; a button and a timed advance on the same frame count once.
  always_comb begin
    frame_start_d = (pixX == '0) && (pixY == '0);
    auto_hit      = 1'b0;
    if (AUTO_CYCLE_FRAMES > 0) begin
      auto_hit = frame_start_q && (frame_cnt_q == 32'(AUTO_CYCLE_FRAMES - 1));
    end
    advance       = (frame_start_q && pending_q) || auto_hit;
    pattern_idx_d = advance ? next_pattern(pattern_idx_q, EFF_PATTERNS) : pattern_idx_q;
    // The rise pulse and the level are aligned, so this qualification is always true on a rise.
    pending_d     = (pending_q && !advance) || (btn_rise && btn_level);
    frame_cnt_d   = frame_cnt_q;
    if (advance) begin
      frame_cnt_d = '0;
    end else if (frame_start_q && (AUTO_CYCLE_FRAMES > 0)) begin
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
  end

`ifdef TPG_MOVING_BAR_EN
  logic [XW-1:0] offset_q, offset_d;

  // Moving-bar position steps by 4 each frame and wraps before running off the screen.
  always_comb begin
    offset_d = offset_q;
    if (frame_start_q) begin
      offset_d = (({1'b0, offset_q} + (XW+1)'(4)) >= {1'b0, screenWidth}) ? '0 : offset_q + XW'(4);
    end
  end

  // Offset register.
  always_ff @(posedge I_clk_pixel or posedge I_reset) begin
    if (I_reset) offset_q <= '0;
    else         offset_q <= offset_d;
  end
`endif

  // Pixel colour for the current coordinate under the active pattern.
  always_comb begin
    rgb_d     = RGB_BLACK;
    in_area   = (pixX < screenWidth) && (pixY < screenHeight);
    on_border = (pixX < XW'(BORDER_W)) || (pixY < YW'(BORDER_W)) ||
                (({1'b0, pixX} + (XW+1)'(BORDER_W)) >= {1'b0, screenWidth}) ||
                (({1'b0, pixY} + (YW+1)'(BORDER_W)) >= {1'b0, screenHeight});
    bar_w     = screenWidth >> 3;
    bar_thr   = '0;
    bar_sel   = 3'd0;
    for (int k = 1; k < 8; k++) begin
      bar_thr = bar_thr + {3'b000, bar_w};
      if ({3'b000, pixX} >= bar_thr) bar_sel = 3'(k);
    end
    case (pattern_e'(pattern_idx_q))
      PAT_BORDER:      rgb_d = on_border ? RGB_WHITE : RGB_BLACK;
      PAT_COLOUR_BARS: rgb_d = COLOUR_BAR_TABLE[bar_sel];
      PAT_CHECKER:     rgb_d = (pixX[5] == pixY[5]) ? RGB_WHITE : RGB_BLACK;
      PAT_GREY_RAMP:   rgb_d = {3{pixX[9:2]}};
      PAT_SOLID_RED:   rgb_d = 24'hFF0000;
      PAT_SOLID_GREEN: rgb_d = 24'h00FF00;
      PAT_SOLID_BLUE:  rgb_d = 24'h0000FF;
`ifdef TPG_MOVING_BAR_EN
      PAT_MOVING_BAR:  rgb_d = (({1'b0, pixX} >= {1'b0, offset_q}) &&
                                ({1'b0, pixX} < ({1'b0, offset_q} + (XW+1)'(16)))) ? RGB_WHITE : RGB_BLACK;
`endif
      default:         rgb_d = RGB_BLACK;
    endcase
    if (!in_area) rgb_d = RGB_BLACK;
  end

  // Output and control registers.
  always_ff @(posedge I_clk_pixel or posedge I_reset) begin
    if (I_reset) begin
      frame_start_q <= 1'b0;
      pending_q     <= 1'b0;
      frame_cnt_q   <= '0;
      pattern_idx_q <= 3'd0;
      rgb_q         <= RGB_BLACK;
    end else begin
      frame_start_q <= frame_start_d;
      pending_q     <= pending_d;
      frame_cnt_q   <= frame_cnt_d;
      pattern_idx_q <= pattern_idx_d;
      rgb_q         <= rgb_d;
    end
  end

  assign rgb         = rgb_q;
  assign pattern_idx = pattern_idx_q;
  assign frame_start = frame_start_q;

endmodule
